// File: rtl/xsum_pkg.sv
// Shared types, default sizes and the adder helper for the xsum frame accumulator.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package xsum_pkg;

  localparam int XSUM_NIN   = 8;
  localparam int XSUM_NACC  = 16;
  localparam int XSUM_FRAME = 4;

  // Widest accumulator the helper below can serve; NACC must not exceed it.
  localparam int XSUM_W_MAX = 32;

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } xsum_state_t;

  // Unsigned add with one carry bit. Callers zero-extend into the fixed width
  // and truncate the result back to NACC+1 bits, which never loses the carry
  // because acc < 2^NACC and din < 2^NIN <= 2^NACC.
  function automatic logic [XSUM_W_MAX:0] xsum_add(
    input logic [XSUM_W_MAX-1:0] acc,
    input logic [XSUM_W_MAX-1:0] din
  );
    return {1'b0, acc} + {1'b0, din};
  endfunction

endpackage

// File: rtl/xsum_frame_ctr.sv
// Sample-in-frame counter: counts accepted samples, flags the last one of a frame.
// Latency: last_o is decoded from the registered count, valid in the same cycle.
// Backpressure: none; advances only on tick_i, clr_i has priority and returns to 0.
module xsum_frame_ctr import xsum_pkg::*; #(
  parameter int FRAME = XSUM_FRAME
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic tick_i,
  input  logic clr_i,
  output logic last_o
);

  localparam int CW = (FRAME > 1) ? $clog2(FRAME) : 1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: clear at end of frame, otherwise step on each accepted sample.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (tick_i) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last_o = (cnt_q == CW'(FRAME - 1));

endmodule

// File: rtl/xsum_accum.sv
// Frame accumulator: sums FRAME unsigned samples, presents total + overflow flag (XSUM_SAT_EN selects clamping instead of wrap).
// Latency: OUT_VALID rises on the edge accepting the last sample; FRAME samples per FRAME+1 cycles at best.
// Backpressure: result held in HOLD while OUT_READY is low; IN_READY is 0 throughout HOLD and during reset.
module xsum_accum import xsum_pkg::*; #(
  parameter int NIN   = XSUM_NIN,
  parameter int NACC  = XSUM_NACC,
  parameter int FRAME = XSUM_FRAME
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [NIN-1:0]  IN_DATA,
  input  logic            IN_VALID,
  output logic            IN_READY,
  output logic [NACC-1:0] OUT_DATA,
  output logic            OUT_OVF,
  output logic            OUT_VALID,
  input  logic            OUT_READY
);

  localparam int SUM_W = NACC + 1;

  xsum_state_t     state_q, state_d;
  logic [NACC-1:0] acc_q, acc_d;
  logic            ovf_q, ovf_d;
  logic [NACC-1:0] out_data_q, out_data_d;
  logic            out_ovf_q, out_ovf_d;
  logic            out_valid_q, out_valid_d;

  logic            in_ready;
  logic            accept;
  logic            last;
  logic            frame_done;
  logic [NACC:0]   sum;
  logic [NACC-1:0] acc_nx;
  logic            ovf_nx;

  // Ready depends only on registered state (plus reset), never on OUT_READY.
  assign in_ready   = (state_q == ACCUM) && !RST;
  assign accept     = IN_VALID && in_ready;
  assign frame_done = accept && last;

  assign sum    = SUM_W'(xsum_add(XSUM_W_MAX'(acc_q), XSUM_W_MAX'(IN_DATA)));
  assign ovf_nx = ovf_q | sum[NACC];

`ifdef XSUM_SAT_EN
  // Clamp at all-ones; a clamped accumulator stays clamped for the rest of the frame.
  assign acc_nx = sum[NACC] ? {NACC{1'b1}} : sum[NACC-1:0];
`else
  assign acc_nx = sum[NACC-1:0];
`endif

  xsum_frame_ctr #(
    .FRAME (FRAME)
  ) u_ctr (
    .clk_i  (CLK),
    .rst_i  (RST),
    .tick_i (accept),
    .clr_i  (frame_done),
    .last_o (last)
  );

  // Next-state: accumulate in ACCUM, publish on the last sample, wait in HOLD for the consumer.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    out_data_d  = out_data_q;
    out_ovf_d   = out_ovf_q;
    out_valid_d = out_valid_q;
    case (state_q)
      ACCUM: begin
        if (accept) begin
          if (last) begin
            out_data_d  = acc_nx;
            out_ovf_d   = ovf_nx;
            out_valid_d = 1'b1;
            acc_d       = '0;
            ovf_d       = 1'b0;
            state_d     = HOLD;
          end else begin
            acc_d = acc_nx;
            ovf_d = ovf_nx;
          end
        end
      end
      HOLD: begin
        if (OUT_READY) begin
          out_valid_d = 1'b0;
          state_d     = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  // State and datapath registers; reset drops any partial frame or pending result.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      out_data_q  <= out_data_d;
      out_ovf_q   <= out_ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign IN_READY  = in_ready;
  assign OUT_DATA  = out_data_q;
  assign OUT_OVF   = out_ovf_q;
  assign OUT_VALID = out_valid_q;

endmodule

// File: tb/tb_xsum_accum.sv
// Directed bench for xsum_accum: default-size instance plus a NACC=9 instance for overflow.
// Inputs change #1 after a rising edge; outputs are checked in the same window.
// Expected values are hand-computed from the frame arithmetic.
module tb_xsum_accum;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;

  logic [7:0]  in_data  = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] out_data;
  logic        out_ovf;
  logic        out_valid;
  logic        out_ready = 1'b1;

  logic [7:0]  n9_in_data  = '0;
  logic        n9_in_valid = 1'b0;
  logic        n9_in_ready;
  logic [8:0]  n9_out_data;
  logic        n9_out_ovf;
  logic        n9_out_valid;
  logic        n9_out_ready = 1'b1;

  int n_chk = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  xsum_accum dut (
    .CLK       (CLK),
    .RST       (RST),
    .IN_DATA   (in_data),
    .IN_VALID  (in_valid),
    .IN_READY  (in_ready),
    .OUT_DATA  (out_data),
    .OUT_OVF   (out_ovf),
    .OUT_VALID (out_valid),
    .OUT_READY (out_ready)
  );

  xsum_accum #(.NIN(8), .NACC(9), .FRAME(4)) dut9 (
    .CLK       (CLK),
    .RST       (RST),
    .IN_DATA   (n9_in_data),
    .IN_VALID  (n9_in_valid),
    .IN_READY  (n9_in_ready),
    .OUT_DATA  (n9_out_data),
    .OUT_OVF   (n9_out_ovf),
    .OUT_VALID (n9_out_valid),
    .OUT_READY (n9_out_ready)
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
  endtask

  task automatic send9(input logic [7:0] d);
    n9_in_valid = 1'b1;
    n9_in_data  = d;
    step();
    n9_in_valid = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    step();
    n_chk++; if (in_ready !== 1'b0)   begin n_err++; $display("FAIL rst_in_ready got=%0b exp=0", in_ready); end
    n_chk++; if (out_valid !== 1'b0)  begin n_err++; $display("FAIL rst_out_valid got=%0b exp=0", out_valid); end
    n_chk++; if (out_data !== 16'd0)  begin n_err++; $display("FAIL rst_out_data got=%0d exp=0", out_data); end
    n_chk++; if (out_ovf !== 1'b0)    begin n_err++; $display("FAIL rst_out_ovf got=%0b exp=0", out_ovf); end
    RST = 1'b0;
    step();
    n_chk++; if (in_ready !== 1'b1)   begin n_err++; $display("FAIL rst_release_in_ready got=%0b exp=1", in_ready); end
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    send(8'd10);
    send(8'd20);
    send(8'd30);
    n_chk++; if (out_valid !== 1'b0)  begin n_err++; $display("FAIL basic_early_valid got=%0b exp=0", out_valid); end
    send(8'd40);
    n_chk++; if (out_valid !== 1'b1)  begin n_err++; $display("FAIL basic_valid got=%0b exp=1", out_valid); end
    n_chk++; if (out_data !== 16'd100) begin n_err++; $display("FAIL basic_data got=%0d exp=100", out_data); end
    n_chk++; if (out_ovf !== 1'b0)    begin n_err++; $display("FAIL basic_ovf got=%0b exp=0", out_ovf); end
    n_chk++; if (in_ready !== 1'b0)   begin n_err++; $display("FAIL basic_hold_ready got=%0b exp=0", in_ready); end
    step();
    n_chk++; if (out_valid !== 1'b0)  begin n_err++; $display("FAIL basic_valid_drop got=%0b exp=0", out_valid); end
    n_chk++; if (in_ready !== 1'b1)   begin n_err++; $display("FAIL basic_ready_back got=%0b exp=1", in_ready); end
  endtask

  task automatic test_bubbles();
    logic       vpat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [7:0] dpat [7] = '{8'd1, 8'd99, 8'd99, 8'd2, 8'd3, 8'd99, 8'd4};
    for (int i = 0; i < 7; i++) begin
      in_valid = vpat[i];
      in_data  = dpat[i];
      step();
      n_chk++;
      if (out_valid !== (i == 6)) begin
        n_err++; $display("FAIL bubbles_valid_cyc%0d got=%0b exp=%0b", i, out_valid, (i == 6));
      end
    end
    in_valid = 1'b0;
    n_chk++; if (out_data !== 16'd10) begin n_err++; $display("FAIL bubbles_data got=%0d exp=10", out_data); end
    step();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(8'd5);
    // Keep offering a sample that must not be taken while the result is pending.
    in_valid = 1'b1;
    in_data  = 8'd99;
    for (int c = 0; c < 6; c++) begin
      n_chk++; if (out_valid !== 1'b1)  begin n_err++; $display("FAIL bp_valid_cyc%0d got=%0b exp=1", c, out_valid); end
      n_chk++; if (out_data !== 16'd20) begin n_err++; $display("FAIL bp_data_cyc%0d got=%0d exp=20", c, out_data); end
      n_chk++; if (in_ready !== 1'b0)   begin n_err++; $display("FAIL bp_ready_cyc%0d got=%0b exp=0", c, in_ready); end
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    n_chk++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_release_valid got=%0b exp=0", out_valid); end
    n_chk++; if (in_ready !== 1'b1)  begin n_err++; $display("FAIL bp_release_ready got=%0b exp=1", in_ready); end
  endtask

  task automatic test_overflow();
    logic [8:0] exp_ovf_data;
`ifdef XSUM_SAT_EN
    exp_ovf_data = 9'd511;
`else
    exp_ovf_data = 9'd288;
`endif
    n9_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) send9(8'd200);
    n_chk++; if (n9_out_valid !== 1'b1) begin n_err++; $display("FAIL ovf_valid got=%0b exp=1", n9_out_valid); end
    n_chk++; if (n9_out_data !== exp_ovf_data) begin n_err++; $display("FAIL ovf_data got=%0d exp=%0d", n9_out_data, exp_ovf_data); end
    n_chk++; if (n9_out_ovf !== 1'b1)   begin n_err++; $display("FAIL ovf_flag got=%0b exp=1", n9_out_ovf); end
    step();
    for (int i = 0; i < 4; i++) send9(8'd1);
    n_chk++; if (n9_out_data !== 9'd4)  begin n_err++; $display("FAIL ovf_next_data got=%0d exp=4", n9_out_data); end
    n_chk++; if (n9_out_ovf !== 1'b0)   begin n_err++; $display("FAIL ovf_next_flag got=%0b exp=0", n9_out_ovf); end
    step();
  endtask

  task automatic test_reset_mid_frame();
    out_ready = 1'b1;
    send(8'd7);
    send(8'd7);
    #3;
    RST = 1'b1;
    #1;
    n_chk++; if (out_data !== 16'd0) begin n_err++; $display("FAIL midrst_data got=%0d exp=0", out_data); end
    n_chk++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_valid got=%0b exp=0", out_valid); end
    n_chk++; if (out_ovf !== 1'b0)   begin n_err++; $display("FAIL midrst_ovf got=%0b exp=0", out_ovf); end
    n_chk++; if (in_ready !== 1'b0)  begin n_err++; $display("FAIL midrst_ready got=%0b exp=0", in_ready); end
    step();
    RST = 1'b0;
    step();
    send(8'd1);
    send(8'd2);
    send(8'd3);
    send(8'd4);
    n_chk++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL midrst_frame_valid got=%0b exp=1", out_valid); end
    n_chk++; if (out_data !== 16'd10) begin n_err++; $display("FAIL midrst_frame_data got=%0d exp=10", out_data); end
    step();
  endtask

  task automatic test_max_no_overflow();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) send(8'd255);
    n_chk++; if (out_data !== 16'd1020) begin n_err++; $display("FAIL max_data got=%0d exp=1020", out_data); end
    n_chk++; if (out_ovf !== 1'b0)      begin n_err++; $display("FAIL max_ovf got=%0b exp=0", out_ovf); end
    step();
  endtask

  initial begin
    #1;
    test_reset();
    test_basic();
    test_bubbles();
    test_backpressure();
    test_overflow();
    test_reset_mid_frame();
    test_max_no_overflow();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/xsum_accum.md
# xsum_accum

Frame accumulator that sits directly downstream of the `xmod_test` adder stage. It consumes the adder's 8-bit sum stream through a valid/ready handshake and adds `FRAME` consecutive samples into an unsigned accumulator. It then presents the frame total, with an overflow flag, on a registered valid/ready output. `XModCallEnt`-style wrappers instantiate it after the adder to reduce per-cycle sums into per-frame totals.

## Interface
Parameters:
- `NIN`, 8, input sample width (matches adder `XOUT` width as used by the wrapper)
- `NACC`, 16, accumulator and output width; must be ≥ `NIN`
- `FRAME`, 4, samples per frame; must be ≥ 2

Ports (one clock; reset is asynchronous and active-high):
- `CLK`  in  1  clock, rising edge
- `RST`  in  1  asynchronous, active-high reset
- `IN_DATA`  in  `NIN`  sample from the adder stage, unsigned
- `IN_VALID`  in  1  `IN_DATA` is valid
- `IN_READY`  out  1  block accepts a sample this cycle
- `OUT_DATA`  out  `NACC`  frame total
- `OUT_OVF`  out  1  frame total exceeded 2^`NACC`−1
- `OUT_VALID`  out  1  `OUT_DATA`/`OUT_OVF` valid
- `OUT_READY`  in  1  consumer accepts the output

## Operation
- States:
  - `ACCUM`: collecting samples.
  - `HOLD`: a frame result is waiting to be consumed.
- Accept condition: `IN_VALID && IN_READY`. `IN_READY = (state == ACCUM)`. It is decoded from registered state only and has no combinational path from `OUT_READY`.
- In `ACCUM`, each accept does the following:
  - computes `sum = acc + zext(IN_DATA)` at `NACC+1` bits;
  - increments `cnt` (range 0..`FRAME`−1);
  - sets `ovf` if `sum[NACC]` is 1. The overflow flag is sticky for the frame.
- Non-final accept: `acc <= sum[NACC-1:0]` (or the saturated value, see Configuration).
- Final accept (`cnt == FRAME-1`):
  - `OUT_DATA` receives the final value and `OUT_OVF` receives the sticky flag including this sample;
  - `OUT_VALID <= 1`;
  - `acc`, `cnt` and `ovf` clear;
  - state goes to `HOLD`.
- `IN_VALID` low in `ACCUM`: no change.
- `HOLD`: `OUT_DATA` and `OUT_OVF` are stable. When `OUT_READY` is high, `OUT_VALID <= 0` and state goes to `ACCUM`.
- `OUT_READY` is ignored while `OUT_VALID` is low.

## Timing
- Reset values: `IN_READY=0` while `RST` is asserted, 1 from the first cycle after release. `OUT_DATA=0`, `OUT_OVF=0`, `OUT_VALID=0`. Internally `acc=0`, `cnt=0`, `ovf=0`, state `ACCUM`.
- Latency: `OUT_VALID` rises on the clock edge that accepts the final sample, so the result is visible one cycle after the final-sample cycle.
- Throughput: at most `FRAME` samples per `FRAME+1` cycles. The `HOLD` cycle blocks input even when `OUT_READY` is already high.
- Back-pressure: `HOLD` persists indefinitely while `OUT_READY` is low, and `IN_READY` stays 0 throughout.
- Reset mid-frame: the partial accumulation is discarded and no output is produced. Reset in `HOLD` drops the pending result.
- Wrap-around: `cnt` returns to 0 after each frame. There is no state carried across frames.

## Configuration
- `XSUM_SAT_EN` defined: when `sum[NACC]` is 1, `acc` and `OUT_DATA` clamp to 2^`NACC`−1. Later samples in the same frame keep the value clamped.
- `XSUM_SAT_EN` undefined: arithmetic wraps modulo 2^`NACC`.
- `OUT_OVF` is reported identically in both modes.

## Structure
- Shared package `xsum_pkg`:
  - state enum `xsum_state_t {ACCUM, HOLD}`;
  - default parameter constants `XSUM_NIN`, `XSUM_NACC`, `XSUM_FRAME`;
  - function `xsum_add(acc, din)` returning the `NACC+1`-bit sum.
- One sub-module, `xsum_frame_ctr`. It holds `cnt`, takes a `tick` (accept) input and a `clr` input, and outputs `last` (`cnt == FRAME-1`).

## Test plan
- Basic frame (defaults): accept 10, 20, 30, 40 on consecutive cycles with `OUT_READY=1`. Expect `OUT_DATA=100`, `OUT_OVF=0` and `OUT_VALID` high for 1 cycle, starting the cycle after 40 is accepted. `IN_READY` is 0 in that cycle.
- Bubbles: `IN_VALID` pattern 1,0,0,1,1,0,1 with data 1,x,x,2,3,x,4. Expect `OUT_DATA=10` after the 4th accepted sample only.
- Back-pressure: complete a frame of 5,5,5,5 with `OUT_READY=0` for 6 cycles. Expect `OUT_DATA=20`, `OUT_VALID=1` and `IN_READY=0` held stable. Raise `OUT_READY`; one cycle later `OUT_VALID=0` and `IN_READY=1`.
- Overflow (`NACC=9`): feed 200 ×4. Without the macro, expect `OUT_DATA=288`, `OUT_OVF=1`. With `XSUM_SAT_EN`, expect `OUT_DATA=511`, `OUT_OVF=1`. The next frame of 1 ×4 gives `OUT_DATA=4`, `OUT_OVF=0`.
- Reset mid-frame: accept 7, 7, then assert `RST` asynchronously between edges. Expect all outputs 0 immediately. After release, a frame of 1,2,3,4 gives `OUT_DATA=10` with no residue from the aborted frame.
- Max no-overflow (defaults): feed 255 ×4. Expect `OUT_DATA=1020`, `OUT_OVF=0`.
